// File: rtl/lock_chamber_ctrl.sv
// Lock chamber controller: sequences the gates and valves for inbound/outbound passages.
// Latency: a request sampled in IDLE enters the first active state on the next edge.
// Backpressure: requests arriving while busy are held as one pending flag per direction.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous active-low reset
//   arriveSignal - one-cycle pulse: inbound passage request (outer/low -> inner/high)
//   departSignal - one-cycle pulse: outbound passage request (inner/high -> outer/low)
//   outerGate    - outer gate open
//   innerGate    - inner gate open
//   fillValve    - chamber filling
//   drainValve   - chamber draining
//   waterLevel   - chamber level, 0..LEVEL_MAX
//   busy         - state is not IDLE
//   tripCount    - completed passages, wraps at 256
module lock_chamber_ctrl #(
  parameter int GATE_TIME = 4,
  parameter int LEVEL_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriveSignal,
  input  logic       departSignal,
  output logic       outerGate,
  output logic       innerGate,
  output logic       fillValve,
  output logic       drainValve,
  output logic [3:0] waterLevel,
  output logic       busy,
  output logic [7:0] tripCount
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] OPEN_OUTER = 3'd1;
  localparam logic [2:0] FILL       = 3'd2;
  localparam logic [2:0] OPEN_INNER = 3'd3;
  localparam logic [2:0] DRAIN      = 3'd4;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int         CW   = (GATE_TIME > 1) ? $clog2(GATE_TIME) : 1;
  localparam logic [3:0] LMAX = 4'(LEVEL_MAX);

  logic [2:0]    state, state_nxt;
  logic          dir, dir_nxt;
  logic [3:0]    level;
  logic [CW-1:0] gate_cnt;
  logic [7:0]    trips;
  logic          pend_arr, pend_dep;
  logic          want_arr, want_dep;
  logic          serve_arr, serve_dep;
  logic          gate_done;

  assign want_arr  = arriveSignal | pend_arr;
  assign want_dep  = departSignal | pend_dep;
  assign gate_done = (gate_cnt == CW'(GATE_TIME - 1));

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    serve_arr = 1'b0;
    serve_dep = 1'b0;
    case (state)
      IDLE: begin
        // Idle level is always 0 or LMAX; on contention pick the direction
        // that can start without prepositioning the water.
        if (want_arr && want_dep) begin
          if (level == LMAX) serve_dep = 1'b1;
          else               serve_arr = 1'b1;
        end else if (want_arr) begin
          serve_arr = 1'b1;
        end else if (want_dep) begin
          serve_dep = 1'b1;
        end
        if (serve_arr) begin
          dir_nxt   = DIR_IN;
          state_nxt = (level == 4'd0) ? OPEN_OUTER : DRAIN;
        end else if (serve_dep) begin
          dir_nxt   = DIR_OUT;
          state_nxt = (level == LMAX) ? OPEN_INNER : FILL;
        end
      end
      OPEN_OUTER: if (gate_done) state_nxt = (dir == DIR_IN) ? FILL : IDLE;
      // Both the inbound fill and the outbound preposition fill end at the inner gate.
      FILL:       if (level >= LMAX - 4'd1) state_nxt = OPEN_INNER;
      OPEN_INNER: if (gate_done) state_nxt = (dir == DIR_IN) ? IDLE : DRAIN;
      // Both the outbound drain and the inbound preposition drain end at the outer gate.
      DRAIN:      if (level <= 4'd1) state_nxt = OPEN_OUTER;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dir      <= DIR_IN;
      level    <= 4'd0;
      gate_cnt <= '0;
      trips    <= 8'd0;
      pend_arr <= 1'b0;
      pend_dep <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;

      if (state == FILL)       level <= level + 4'd1;
      else if (state == DRAIN) level <= level - 4'd1;

      // Counter restarts on every state change so each gate phase starts at 0.
      if (state_nxt != state)
        gate_cnt <= '0;
      else if (state == OPEN_OUTER || state == OPEN_INNER)
        gate_cnt <= gate_cnt + 1'b1;

      if (state != IDLE && state_nxt == IDLE)
        trips <= trips + 8'd1;

      if (state != IDLE) begin
        // Includes the cycle that returns to IDLE, so no request is dropped.
        pend_arr <= pend_arr | arriveSignal;
        pend_dep <= pend_dep | departSignal;
      end else if (serve_arr) begin
        pend_arr <= 1'b0;
        pend_dep <= pend_dep | departSignal;
      end else if (serve_dep) begin
        pend_dep <= 1'b0;
        pend_arr <= pend_arr | arriveSignal;
      end
    end
  end

  assign outerGate  = (state == OPEN_OUTER);
  assign innerGate  = (state == OPEN_INNER);
  assign fillValve  = (state == FILL);
  assign drainValve = (state == DRAIN);
  assign busy       = (state != IDLE);
  assign waterLevel = level;
  assign tripCount  = trips;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Directed bench for lock_chamber_ctrl: passage sequences, pending collapse,
// contention, reset abort and trip counter wrap.
module tb_lock_chamber_ctrl;

  logic       clk;
  logic       rst;
  logic       arriveSignal;
  logic       departSignal;
  logic       outerGate;
  logic       innerGate;
  logic       fillValve;
  logic       drainValve;
  logic [3:0] waterLevel;
  logic       busy;
  logic [7:0] tripCount;

  int total = 0;
  int bad   = 0;

  // Output vector {outerGate, innerGate, fillValve, drainValve, busy}
  localparam logic [4:0] V_IDLE  = 5'b00000;
  localparam logic [4:0] V_OUTER = 5'b10001;
  localparam logic [4:0] V_INNER = 5'b01001;
  localparam logic [4:0] V_FILL  = 5'b00101;
  localparam logic [4:0] V_DRAIN = 5'b00011;

  lock_chamber_ctrl #(.GATE_TIME(4), .LEVEL_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .arriveSignal (arriveSignal),
    .departSignal (departSignal),
    .outerGate    (outerGate),
    .innerGate    (innerGate),
    .fillValve    (fillValve),
    .drainValve   (drainValve),
    .waterLevel   (waterLevel),
    .busy         (busy),
    .tripCount    (tripCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {outerGate, innerGate, fillValve, drainValve, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n consecutive cycles of one state; optionally pulses a request
  // during cycle index pidx of the segment.
  task automatic seg(input string tag, input logic [4:0] v, input int n,
                     input int l0, input int stp, input int pidx,
                     input logic pa, input logic pd);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_out%0d", tag, i), 32'(outs()), 32'(v));
      chk($sformatf("%s_lvl%0d", tag, i), 32'(waterLevel), 32'(l0 + i * stp));
      if (i == pidx) begin
        arriveSignal = pa;
        departSignal = pd;
      end
      tick();
      arriveSignal = 1'b0;
      departSignal = 1'b0;
    end
  endtask

  task automatic idle_chk(input string tag, input int lvl, input int trips);
    chk({tag, "_out"},  32'(outs()),     32'(V_IDLE));
    chk({tag, "_lvl"},  32'(waterLevel), 32'(lvl));
    chk({tag, "_trip"}, 32'(tripCount),  32'(trips));
  endtask

  task automatic req(input logic a, input logic d);
    arriveSignal = a;
    departSignal = d;
    tick();
    arriveSignal = 1'b0;
    departSignal = 1'b0;
  endtask

  task automatic passage(input logic a, input logic d);
    req(a, d);
    repeat (16) tick();
  endtask

  initial begin
    rst = 1'b0;
    arriveSignal = 1'b0;
    departSignal = 1'b0;
    #1;
    idle_chk("reset", 0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    idle_chk("post_reset", 0, 0);

    // Inbound from level 0
    req(1'b1, 1'b0);
    seg("in_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    seg("in_fill",  V_FILL,  8, 0, 1, -1, 1'b0, 1'b0);
    seg("in_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    idle_chk("in_done", 8, 1);

    // Inbound from level 8: preposition drain, 24 busy cycles
    req(1'b1, 1'b0);
    seg("pin_drain", V_DRAIN, 8, 8, -1, -1, 1'b0, 1'b0);
    seg("pin_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    seg("pin_fill",  V_FILL,  8, 0, 1, -1, 1'b0, 1'b0);
    seg("pin_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    idle_chk("pin_done", 8, 2);

    // Outbound from level 8
    req(1'b0, 1'b1);
    seg("out_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    seg("out_drain", V_DRAIN, 8, 8, -1, -1, 1'b0, 1'b0);
    seg("out_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    idle_chk("out_done", 0, 3);

    // Three depart pulses during inbound; last one coincides with return to IDLE
    req(1'b1, 1'b0);
    seg("col_outer", V_OUTER, 4, 0, 0, 1, 1'b0, 1'b1);
    seg("col_fill",  V_FILL,  8, 0, 1, 3, 1'b0, 1'b1);
    seg("col_inner", V_INNER, 4, 8, 0, 3, 1'b0, 1'b1);
    idle_chk("col_idle", 8, 4);
    tick();
    seg("col_d_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    seg("col_d_drain", V_DRAIN, 8, 8, -1, -1, 1'b0, 1'b0);
    seg("col_d_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    idle_chk("col_d_done", 0, 5);
    tick();
    idle_chk("col_no_extra", 0, 5);

    // Simultaneous requests at level 0: inbound first, then outbound
    req(1'b1, 1'b1);
    seg("both_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    seg("both_fill",  V_FILL,  8, 0, 1, -1, 1'b0, 1'b0);
    seg("both_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    idle_chk("both_mid", 8, 6);
    tick();
    seg("both_d_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    seg("both_d_drain", V_DRAIN, 8, 8, -1, -1, 1'b0, 1'b0);
    seg("both_d_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    idle_chk("both_done", 0, 7);

    // Outbound from level 0: preposition fill
    req(1'b0, 1'b1);
    seg("pout_fill",  V_FILL,  8, 0, 1, -1, 1'b0, 1'b0);
    seg("pout_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    seg("pout_drain", V_DRAIN, 8, 8, -1, -1, 1'b0, 1'b0);
    seg("pout_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    idle_chk("pout_done", 0, 8);

    // Reset during FILL at level 5
    req(1'b1, 1'b0);
    seg("rst_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    seg("rst_fill",  V_FILL,  5, 0, 1, -1, 1'b0, 1'b0);
    chk("rst_pre_out", 32'(outs()), 32'(V_FILL));
    chk("rst_pre_lvl", 32'(waterLevel), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    idle_chk("rst_async", 0, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_chk($sformatf("rst_quiet%0d", i), 0, 0);
    end
    req(1'b1, 1'b0);
    seg("rec_outer", V_OUTER, 4, 0, 0, -1, 1'b0, 1'b0);
    seg("rec_fill",  V_FILL,  8, 0, 1, -1, 1'b0, 1'b0);
    seg("rec_inner", V_INNER, 4, 8, 0, -1, 1'b0, 1'b0);
    idle_chk("rec_done", 8, 1);

    // Trip counter wrap: alternate depart/arrive so no prepositioning occurs
    for (int k = 2; k <= 255; k++) begin
      if (k % 2 == 0) passage(1'b0, 1'b1);
      else            passage(1'b1, 1'b0);
    end
    idle_chk("wrap_255", 8, 255);
    passage(1'b0, 1'b1);
    idle_chk("wrap_0", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
